// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants shared by the timing generator
// and the sprite stages, plus the sync bundle carried down the pipe.
package vga_timing_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;

  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_H_TOTAL =
    DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL =
    DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam logic DEF_SYNC_POL   = 1'b0;
  localparam int   DEF_PIPE_DELAY = 2;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } sync_t;

  // Half-open range test lo <= v < hi on a 10-bit counter.
  function automatic logic in_span(
    input logic [9:0] v,
    input int         lo,
    input int         hi
  );
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster bundle from the timing generator to the sprite stages and pins.
interface vga_timing_if;

  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        blank;
  logic        hs;
  logic        vs;
  logic        hs_d;
  logic        vs_d;
  logic        blank_d;
  logic        line_start;
  logic        frame_start;
  logic        vblank_start;
  logic [15:0] frame_count;

  modport master (
    output DrawX, DrawY, blank, hs, vs,
    output hs_d, vs_d, blank_d,
    output line_start, frame_start, vblank_start,
    output frame_count
  );

  modport slave (
    input DrawX, DrawY, blank, hs, vs,
    input hs_d, vs_d, blank_d,
    input line_start, frame_start, vblank_start,
    input frame_count
  );

endinterface

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register with synchronous flush; depth 0 is a wire.
module sync_delay_line #(
  parameter int             W       = 3,
  parameter int             DEPTH   = 2,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         vga_clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    assign q = d;
  end else begin : g_pipe
    logic [W-1:0] sr [DEPTH];

    always_ff @(posedge vga_clk) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++)
          sr[i] <= RST_VAL;
      end else begin
        sr[0] <= d;
        for (int i = 1; i < DEPTH; i++)
          sr[i] <= sr[i-1];
      end
    end

    assign q = sr[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel counters, registered sync/blank decode,
// frame pacing strobes and a delayed sync copy for the sprite pipe.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_VISIBLE  = DEF_H_VISIBLE,
  parameter int   H_FRONT    = DEF_H_FRONT,
  parameter int   H_SYNC     = DEF_H_SYNC,
  parameter int   H_BACK     = DEF_H_BACK,
  parameter int   V_VISIBLE  = DEF_V_VISIBLE,
  parameter int   V_FRONT    = DEF_V_FRONT,
  parameter int   V_SYNC     = DEF_V_SYNC,
  parameter int   V_BACK     = DEF_V_BACK,
  parameter logic SYNC_POL   = DEF_SYNC_POL,
  parameter int   PIPE_DELAY = DEF_PIPE_DELAY
) (
  input logic          vga_clk,
  input logic          reset,
  vga_timing_if.master vga
);

  localparam int HT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int VT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int HS_LO = H_VISIBLE + H_FRONT;
  localparam int HS_HI = HS_LO + H_SYNC;
  localparam int VS_LO = V_VISIBLE + V_FRONT;
  localparam int VS_HI = VS_LO + V_SYNC;

  localparam logic [9:0] H_LAST = 10'(HT - 1);
  localparam logic [9:0] V_LAST = 10'(VT - 1);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);

  if (HT > 1024 || VT > 1024) begin : g_bad_timing
    $error("vga_timing_gen: H/V totals exceed 10-bit counters");
  end

  logic [9:0]  x_q, y_q;
  logic [9:0]  x_n, y_n;
  logic        blank_q, hs_q, vs_q;
  logic        blank_n, hs_n, vs_n;
  logic        ls_q, fs_q, vbs_q;
  logic        ls_n, fs_n, vbs_n;
  logic [15:0] fc_q;

  always_comb begin
    x_n = x_q + 10'd1;
    y_n = y_q;
    if (x_q == H_LAST) begin
      x_n = '0;
      y_n = (y_q == V_LAST) ? '0 : y_q + 10'd1;
    end
  end

  // Decode the pixel the counters are about to show, so the
  // registered flags line up with DrawX/DrawY.
  always_comb begin
    blank_n = in_span(x_n, 0, H_VISIBLE)
           && in_span(y_n, 0, V_VISIBLE);
    hs_n    = in_span(x_n, HS_LO, HS_HI) ? SYNC_POL : ~SYNC_POL;
    vs_n    = in_span(y_n, VS_LO, VS_HI) ? SYNC_POL : ~SYNC_POL;
    ls_n    = (x_n == '0);
    fs_n    = ls_n && (y_n == '0);
    vbs_n   = ls_n && (y_n == V_VIS);
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      x_q     <= H_LAST;
      y_q     <= V_LAST;
      blank_q <= 1'b0;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      vbs_q   <= 1'b0;
      fc_q    <= '0;
    end else begin
      x_q     <= x_n;
      y_q     <= y_n;
      blank_q <= blank_n;
      hs_q    <= hs_n;
      vs_q    <= vs_n;
      ls_q    <= ls_n;
      fs_q    <= fs_n;
      vbs_q   <= vbs_n;
      fc_q    <= fc_q + 16'(vbs_n);
    end
  end

  localparam sync_t SYNC_RST = '{
    hs:    ~SYNC_POL,
    vs:    ~SYNC_POL,
    blank: 1'b0
  };

  sync_t sync_cur;
  sync_t sync_dly;

  assign sync_cur = '{hs: hs_q, vs: vs_q, blank: blank_q};

  sync_delay_line #(
    .W      (3),
    .DEPTH  (PIPE_DELAY),
    .RST_VAL(SYNC_RST)
  ) u_dly (
    .vga_clk(vga_clk),
    .reset  (reset),
    .d      (sync_cur),
    .q      (sync_dly)
  );

  assign vga.DrawX        = x_q;
  assign vga.DrawY        = y_q;
  assign vga.blank        = blank_q;
  assign vga.hs           = hs_q;
  assign vga.vs           = vs_q;
  assign vga.hs_d         = sync_dly.hs;
  assign vga.vs_d         = sync_dly.vs;
  assign vga.blank_d      = sync_dly.blank;
  assign vga.line_start   = ls_q;
  assign vga.frame_start  = fs_q;
  assign vga.vblank_start = vbs_q;
  assign vga.frame_count  = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default, reduced and zero-delay builds
// checked against a position-from-time raster model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        hs_d;
    logic        vs_d;
    logic        blank_d;
    logic        ls;
    logic        fs;
    logic        vbs;
    logic [15:0] fc;
  } obs_t;

  typedef struct {
    int hv, hf, hs, hb;
    int vv, vf, vs, vb;
    bit pol;
    int d;
  } tim_t;

  typedef struct {
    int         t;
    logic [9:0] x;
    logic [9:0] y;
    logic       bl;
    logic       hs;
    logic       ls;
    logic       fs;
    logic       bd;
    logic       hd;
  } vec_t;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  longint t = -1;
  int     n_pass = 0;
  int     n_tot = 0;

  always #5 clk = ~clk;

  vga_timing_if if_def ();
  vga_timing_if if_red ();
  vga_timing_if if_z ();

  vga_timing_gen u_def (
    .vga_clk(clk),
    .reset  (reset),
    .vga    (if_def)
  );

  vga_timing_gen #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
    .V_VISIBLE(8),  .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .SYNC_POL(1'b1), .PIPE_DELAY(3)
  ) u_red (
    .vga_clk(clk),
    .reset  (reset),
    .vga    (if_red)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_POL(1'b0), .PIPE_DELAY(0)
  ) u_z (
    .vga_clk(clk),
    .reset  (reset),
    .vga    (if_z)
  );

  obs_t o_def, o_red, o_z;

  assign o_def = {if_def.DrawX, if_def.DrawY, if_def.blank,
                  if_def.hs, if_def.vs, if_def.hs_d, if_def.vs_d,
                  if_def.blank_d, if_def.line_start,
                  if_def.frame_start, if_def.vblank_start,
                  if_def.frame_count};
  assign o_red = {if_red.DrawX, if_red.DrawY, if_red.blank,
                  if_red.hs, if_red.vs, if_red.hs_d, if_red.vs_d,
                  if_red.blank_d, if_red.line_start,
                  if_red.frame_start, if_red.vblank_start,
                  if_red.frame_count};
  assign o_z   = {if_z.DrawX, if_z.DrawY, if_z.blank,
                  if_z.hs, if_z.vs, if_z.hs_d, if_z.vs_d,
                  if_z.blank_d, if_z.line_start,
                  if_z.frame_start, if_z.vblank_start,
                  if_z.frame_count};

  tim_t p_def, p_red, p_z;

  // Sync/blank for the pixel shown t cycles after release;
  // negative t means the reset state.
  function automatic void sync_at(
    input tim_t p, input longint tt,
    output bit b, output bit h, output bit v
  );
    longint ht, vt, x, y;
    ht = p.hv + p.hf + p.hs + p.hb;
    vt = p.vv + p.vf + p.vs + p.vb;
    if (tt < 0) begin
      b = 1'b0; h = !p.pol; v = !p.pol;
      return;
    end
    x = tt % ht;
    y = (tt / ht) % vt;
    b = (x < p.hv) && (y < p.vv);
    h = (x >= p.hv + p.hf && x < p.hv + p.hf + p.hs) ? p.pol : !p.pol;
    v = (y >= p.vv + p.vf && y < p.vv + p.vf + p.vs) ? p.pol : !p.pol;
  endfunction

  function automatic obs_t model(input tim_t p, input longint tt);
    obs_t o;
    longint ht, vt, ft, x, y, off;
    bit b, h, v, bd, hd, vd;
    ht = p.hv + p.hf + p.hs + p.hb;
    vt = p.vv + p.vf + p.vs + p.vb;
    ft = ht * vt;
    off = p.vv * ht;
    o = '0;
    sync_at(p, tt, b, h, v);
    sync_at(p, tt - p.d, bd, hd, vd);
    o.blank = b; o.hs = h; o.vs = v;
    o.blank_d = bd; o.hs_d = hd; o.vs_d = vd;
    if (tt < 0) begin
      o.x = 10'(ht - 1);
      o.y = 10'(vt - 1);
    end else begin
      x = tt % ht;
      y = (tt / ht) % vt;
      o.x = 10'(x);
      o.y = 10'(y);
      o.ls = (x == 0);
      o.fs = (x == 0) && (y == 0);
      o.vbs = (x == 0) && (y == p.vv);
      if (tt >= off) o.fc = 16'((tt - off) / ft + 1);
    end
    return o;
  endfunction

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    n_tot++;
    if (a === e) n_pass++;
    else $display("FAIL %s t=%0d got %h want %h", nm, t, a, e);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset) t = -1;
    else t++;
    @(negedge clk);
    chk("def", 64'(o_def), 64'(model(p_def, t)));
    chk("red", 64'(o_red), 64'(model(p_red, t)));
    chk("zero", 64'(o_z), 64'(model(p_z, t)));
    chk("zero_align", 64'({if_z.blank_d, if_z.hs_d, if_z.vs_d}),
        64'({if_z.blank, if_z.hs, if_z.vs}));
  endtask

  vec_t tbl[16];

  initial begin
    int  vcnt;
    bit  found;

    p_def = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 2};
    p_red = '{16, 2, 4, 2, 8, 2, 2, 2, 1'b1, 3};
    p_z   = '{8, 1, 2, 1, 4, 1, 1, 1, 1'b0, 0};

    tbl[0]  = '{-1,  10'd799, 10'd524, 0, 1, 0, 0, 0, 1};
    tbl[1]  = '{0,   10'd0,   10'd0,   1, 1, 1, 1, 0, 1};
    tbl[2]  = '{1,   10'd1,   10'd0,   1, 1, 0, 0, 0, 1};
    tbl[3]  = '{2,   10'd2,   10'd0,   1, 1, 0, 0, 1, 1};
    tbl[4]  = '{639, 10'd639, 10'd0,   1, 1, 0, 0, 1, 1};
    tbl[5]  = '{640, 10'd640, 10'd0,   0, 1, 0, 0, 1, 1};
    tbl[6]  = '{642, 10'd642, 10'd0,   0, 1, 0, 0, 0, 1};
    tbl[7]  = '{655, 10'd655, 10'd0,   0, 1, 0, 0, 0, 1};
    tbl[8]  = '{656, 10'd656, 10'd0,   0, 0, 0, 0, 0, 1};
    tbl[9]  = '{658, 10'd658, 10'd0,   0, 0, 0, 0, 0, 0};
    tbl[10] = '{751, 10'd751, 10'd0,   0, 0, 0, 0, 0, 0};
    tbl[11] = '{752, 10'd752, 10'd0,   0, 1, 0, 0, 0, 0};
    tbl[12] = '{754, 10'd754, 10'd0,   0, 1, 0, 0, 0, 1};
    tbl[13] = '{799, 10'd799, 10'd0,   0, 1, 0, 0, 0, 1};
    tbl[14] = '{800, 10'd0,   10'd1,   1, 1, 1, 0, 0, 1};
    tbl[15] = '{802, 10'd2,   10'd1,   1, 1, 0, 0, 1, 1};

    reset = 1'b1;
    repeat (5) cycle();

    for (int k = 0; k < 16; k++) begin
      if (tbl[k].t >= 0) reset = 1'b0;
      while (t < tbl[k].t) cycle();
      chk($sformatf("line_t%0d", tbl[k].t),
          64'({if_def.DrawX, if_def.DrawY, if_def.blank, if_def.hs,
               if_def.line_start, if_def.frame_start,
               if_def.blank_d, if_def.hs_d}),
          64'({tbl[k].x, tbl[k].y, tbl[k].bl, tbl[k].hs,
               tbl[k].ls, tbl[k].fs, tbl[k].bd, tbl[k].hd}));
    end

    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (if_red.DrawX == 10'd5 && if_red.DrawY == 10'd3) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
    chk("mid_wait", 64'(found), 64'(1));

    reset = 1'b1;
    cycle();
    chk("mid_rst",
        64'({if_red.DrawX, if_red.DrawY, if_red.blank, if_red.hs,
             if_red.vs, if_red.frame_start, if_red.frame_count}),
        64'({10'd23, 10'd13, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0}));
    reset = 1'b0;
    cycle();
    chk("mid_restart",
        64'({if_red.DrawX, if_red.DrawY, if_red.blank,
             if_red.frame_start, if_red.line_start}),
        64'({10'd0, 10'd0, 1'b1, 1'b1, 1'b1}));

    vcnt = 0;
    for (int i = 0; i < 1200; i++) begin
      cycle();
      if (if_red.vblank_start) vcnt++;
      if (vcnt == 3) break;
    end
    chk("fc_third_vblank",
        64'({if_red.frame_count, if_red.DrawX, if_red.DrawY}),
        64'({16'd3, 10'd0, 10'd8}));

    for (int i = 0; i < 20000; i++) begin
      reset = ($urandom_range(0, 2999) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
